// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default baud divider / busy timeout, byte width, and a small width helper.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W           = 8;
    localparam int BAUD_DIV_DEF     = 16;   // 29.49 MHz / 16 = 1.8432 MHz
    localparam int BUSY_TIMEOUT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts one position after the
// last granted requester and wraps, so the previous winner has lowest priority.
// Ports:
//   i_req        - request vector
//   i_last_grant - index of the most recently granted requester
//   o_winner     - one-hot winner (all zero when no request is pending)
// ----------------------------------------------------------------------------
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LG_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [LG_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_winner
);

    logic            w_found;
    logic [LG_W-1:0] w_idx;
    int              w_pos;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        w_pos    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(i_last_grant) + k) % NUM_REQ;
            w_idx = LG_W'(w_pos);
            if (!w_found && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte requesters. Generates the
// baud clock enable, arbitrates round-robin, presents the winning byte and a
// start trigger, then tracks the transmitter busy handshake with a timeout.
// Ports:
//   clk_29_pll    - system clock
//   reset         - synchronous active-low reset
//   i_req         - per-requester byte request (held until granted)
//   i_req_data    - requester i byte at [i]
//   o_grant       - one-hot, one-cycle accept pulse
//   o_baud_en     - one-cycle pulse every BAUD_DIV clocks
//   o_tx_data     - byte presented to the transmitter
//   o_tx_trig     - transmit start request (high throughout LAUNCH)
//   i_tx_busy     - transmitter busy, changes only on baud_en cycles
//   o_active      - high whenever the FSM is not IDLE
//   o_err_timeout - one-cycle pulse when the transmitter never went busy
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BAUD_DIV     = BAUD_DIV_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                           clk_29_pll,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ-1:0][BYTE_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_baud_en,
    output logic [BYTE_W-1:0]              o_tx_data,
    output logic                           o_tx_trig,
    input  logic                           i_tx_busy,
    output logic                           o_active,
    output logic                           o_err_timeout
);

    localparam int LG_W = clog2_min1(NUM_REQ);
    localparam int BC_W = clog2_min1(BAUD_DIV);
    localparam int TO_W = clog2_min1(BUSY_TIMEOUT);

    localparam logic [BC_W-1:0] BAUD_MAX  = BC_W'(BAUD_DIV - 1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [LG_W-1:0] LAST_RST  = LG_W'(NUM_REQ - 1);

    tx_state_t             r_state, w_state_nxt;
    logic [BC_W-1:0]       r_baud_cnt, w_baud_cnt_nxt;
    logic                  r_baud_en;
    logic [TO_W-1:0]       r_to_cnt, w_to_cnt_nxt;
    logic [LG_W-1:0]       r_last_grant;
    logic [NUM_REQ-1:0]    r_grant;
    logic [BYTE_W-1:0]     r_tx_data;
    logic                  r_tx_trig;
    logic                  r_active;
    logic                  r_err;

    logic                  w_take;
    logic                  w_err_nxt;
    logic [NUM_REQ-1:0]    w_winner;
    logic [LG_W-1:0]       w_win_idx;
    logic [BYTE_W-1:0]     w_win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LG_W    (LG_W)
    ) u_arb (
        .i_req        (i_req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) w_win_idx = LG_W'(i);
        end
        w_win_data = i_req_data[w_win_idx];
    end

    assign w_baud_cnt_nxt = (r_baud_cnt == BAUD_MAX) ? '0 : r_baud_cnt + BC_W'(1);

    // Next-state logic. Decisions use the registered baud_en, i.e. the pulse
    // the transmitter sees in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = r_to_cnt;
        w_err_nxt    = 1'b0;
        w_take       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_to_cnt_nxt = '0;
                if (|i_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_to_cnt_nxt = '0;
                if (r_baud_en) w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_nxt  = ST_WAIT_DONE;
                    w_to_cnt_nxt = '0;
                end else if (r_baud_en) begin
                    if (r_to_cnt == TO_MAX) begin
                        w_state_nxt  = ST_IDLE;
                        w_err_nxt    = 1'b1;
                        w_to_cnt_nxt = '0;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
                end
            end
            ST_WAIT_DONE: begin
                w_to_cnt_nxt = '0;
                if (!i_tx_busy) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register they describe.
    always_ff @(posedge clk_29_pll) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_baud_cnt   <= '0;
            r_baud_en    <= 1'b0;
            r_to_cnt     <= '0;
            r_last_grant <= LAST_RST;
            r_grant      <= '0;
            r_tx_data    <= '0;
            r_tx_trig    <= 1'b0;
            r_active     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_baud_en  <= (w_baud_cnt_nxt == BAUD_MAX);
            r_to_cnt   <= w_to_cnt_nxt;
            r_tx_trig  <= (w_state_nxt == ST_LAUNCH);
            r_active   <= (w_state_nxt != ST_IDLE);
            r_err      <= w_err_nxt;
            r_grant    <= '0;
            if (w_take) begin
                r_grant      <= w_winner;
                r_tx_data    <= w_win_data;
                r_last_grant <= w_win_idx;
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_baud_en     = r_baud_en;
    assign o_tx_data     = r_tx_data;
    assign o_tx_trig     = r_tx_trig;
    assign o_active      = r_active;
    assign o_err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench: a table of arbitration vectors plus hand-written sequences
// for baud timing, busy timeout, request withdrawal and mid-transfer reset.
// A small transmitter model raises tx_busy on the baud_en edge that sees
// tx_trig and holds it for busy_len baud_en pulses.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic             clk_29_pll = 1'b0;
    logic             reset      = 1'b0;
    logic [3:0]       i_req      = '0;
    logic [3:0][7:0]  i_req_data = '0;
    logic [3:0]       o_grant;
    logic             o_baud_en;
    logic [7:0]       o_tx_data;
    logic             o_tx_trig;
    logic             i_tx_busy  = 1'b0;
    logic             o_active;
    logic             o_err_timeout;

    int n_vec = 0;
    int n_bad = 0;

    // transmitter model controls
    logic xmit_en  = 1'b1;
    int   busy_len = 3;
    int   busy_left = 0;

    always #17 clk_29_pll = ~clk_29_pll;

    uart_tx_arbiter dut (
        .clk_29_pll    (clk_29_pll),
        .reset         (reset),
        .i_req         (i_req),
        .i_req_data    (i_req_data),
        .o_grant       (o_grant),
        .o_baud_en     (o_baud_en),
        .o_tx_data     (o_tx_data),
        .o_tx_trig     (o_tx_trig),
        .i_tx_busy     (i_tx_busy),
        .o_active      (o_active),
        .o_err_timeout (o_err_timeout)
    );

    always @(posedge clk_29_pll) begin
        if (!reset) begin
            i_tx_busy <= 1'b0;
            busy_left <= 0;
        end else if (!i_tx_busy) begin
            if (xmit_en && o_baud_en && o_tx_trig) begin
                i_tx_busy <= 1'b1;
                busy_left <= busy_len;
            end
        end else if (o_baud_en) begin
            if (busy_left <= 1) i_tx_busy <= 1'b0;
            else                busy_left <= busy_left - 1;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_tx;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the FSM idle: drive the request and check the
    // grant registered at the following edge.
    task automatic launch(input string nm, input logic [3:0] rq, input logic [31:0] dat,
                          input logic [3:0] eg, input logic [7:0] et);
        i_req      = rq;
        i_req_data = dat;
        @(posedge clk_29_pll); #1;
        chk({nm, "_grant"}, {28'd0, o_grant}, {28'd0, eg});
        chk({nm, "_txdata"}, {24'd0, o_tx_data}, {24'd0, et});
        chk({nm, "_trig"}, {31'd0, o_tx_trig}, 32'd1);
    endtask

    // Full transfer: grant, then run to IDLE watching grant width, trigger
    // alignment with baud_en and tx_data stability.
    task automatic run_vec(input string nm, input logic [3:0] rq, input logic [31:0] dat,
                           input logic [3:0] eg, input logic [7:0] et);
        int   gcnt;
        int   tbcnt;
        int   dchg;
        logic done;
        launch(nm, rq, dat, eg, et);
        gcnt = 0; tbcnt = 0; dchg = 0; done = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(negedge clk_29_pll);
            if (c == 0) i_req = '0;
            if (o_grant != 4'd0)        gcnt++;
            if (o_baud_en && o_tx_trig) tbcnt++;
            if (o_tx_data !== et)       dchg++;
            if (!o_active)              done = 1'b1;
        end
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_gpulse"}, gcnt, 1);
        chk({nm, "_trig_bauds"}, tbcnt, 1);
        chk({nm, "_data_hold"}, dchg, 0);
        chk({nm, "_busy_at_idle"}, {31'd0, i_tx_busy}, 32'd0);
    endtask

    task automatic chk_rst_outputs(input string nm);
        chk({nm, "_grant"}, {28'd0, o_grant}, 32'd0);
        chk({nm, "_txdata"}, {24'd0, o_tx_data}, 32'd0);
        chk({nm, "_trig"}, {31'd0, o_tx_trig}, 32'd0);
        chk({nm, "_active"}, {31'd0, o_active}, 32'd0);
        chk({nm, "_err"}, {31'd0, o_err_timeout}, 32'd0);
        chk({nm, "_baud"}, {31'd0, o_baud_en}, 32'd0);
    endtask

    initial begin
        int   first_n;
        int   per;
        int   bcnt;
        int   pcyc;
        int   g1;
        int   errs;
        logic got;
        logic act_at;
        logic done;

        //            req      data           grant    tx
        tbl[0]  = '{4'b1111, 32'h03020100, 4'b0001, 8'h00};
        tbl[1]  = '{4'b1111, 32'h13121110, 4'b0010, 8'h11};
        tbl[2]  = '{4'b1111, 32'h23222120, 4'b0100, 8'h22};
        tbl[3]  = '{4'b1111, 32'h33323130, 4'b1000, 8'h33};
        tbl[4]  = '{4'b1111, 32'h43424140, 4'b0001, 8'h40};
        tbl[5]  = '{4'b0100, 32'h53525150, 4'b0100, 8'h52};
        tbl[6]  = '{4'b0101, 32'h63626160, 4'b0001, 8'h60};  // last=2: search 3,0
        tbl[7]  = '{4'b1001, 32'h73727170, 4'b1000, 8'h73};
        tbl[8]  = '{4'b0110, 32'h83828180, 4'b0010, 8'h81};
        tbl[9]  = '{4'b0010, 32'h93929190, 4'b0010, 8'h91};  // only self: wraps back
        tbl[10] = '{4'b1000, 32'hA3A2A1A0, 4'b1000, 8'hA3};
        tbl[11] = '{4'b1101, 32'hB3B2B1B0, 4'b0001, 8'hB0};

        // reset state
        reset = 1'b0;
        repeat (3) @(posedge clk_29_pll);
        @(negedge clk_29_pll);
        chk_rst_outputs("reset");
        reset = 1'b1;

        // baud_en: first pulse 15 clocks after release, then every 16
        first_n = 0;
        for (int c = 1; c <= 40 && first_n == 0; c++) begin
            @(negedge clk_29_pll);
            if (o_baud_en) first_n = c;
        end
        chk("baud_first", first_n, 15);
        per = 0;
        for (int c = 1; c <= 40 && per == 0; c++) begin
            @(negedge clk_29_pll);
            if (o_baud_en) per = c;
        end
        chk("baud_period", per, 16);

        // single request, long transfer
        busy_len = 152;
        run_vec("single", 4'b0010, 32'h1122A533, 4'b0010, 8'hA5);

        // fresh reset, then the arbitration table
        reset = 1'b0;
        repeat (2) @(posedge clk_29_pll);
        @(negedge clk_29_pll);
        reset = 1'b1;
        busy_len = 3;
        for (int v = 0; v < 12; v++) begin
            run_vec($sformatf("tbl%0d", v), tbl[v].req, tbl[v].data,
                    tbl[v].exp_grant, tbl[v].exp_tx);
        end

        // timeout: transmitter never goes busy
        xmit_en = 1'b0;
        launch("tmo", 4'b0001, 32'hC3C2C1C0, 4'b0001, 8'hC0);
        bcnt = 0; got = 1'b0; act_at = 1'b1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk_29_pll);
            if (c == 0) i_req = '0;
            if (o_err_timeout) begin
                got    = 1'b1;
                act_at = o_active;
            end else if (o_baud_en && !o_tx_trig && o_active) begin
                bcnt++;
            end
        end
        chk("tmo_seen", {31'd0, got}, 32'd1);
        chk("tmo_bauds", bcnt, 4);
        chk("tmo_idle", {31'd0, act_at}, 32'd0);
        @(negedge clk_29_pll);
        chk("tmo_pulse_width", {31'd0, o_err_timeout}, 32'd0);
        xmit_en = 1'b1;
        run_vec("tmo_recover", 4'b0010, 32'hC7C6C5C4, 4'b0010, 8'hC5);

        // withdrawal: req[1] pulsed only while the transmitter is busy
        busy_len = 20;
        launch("wd", 4'b0001, 32'hD3D2D1D0, 4'b0001, 8'hD0);
        g1 = 0; pcyc = 0; done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk_29_pll);
            if (o_grant[1]) g1++;
            if (i_tx_busy && pcyc < 3) begin
                i_req = 4'b0010;
                pcyc++;
            end else begin
                i_req = '0;
            end
            if (!o_active) done = 1'b1;
        end
        repeat (5) begin
            @(negedge clk_29_pll);
            if (o_grant[1]) g1++;
        end
        chk("wd_done", {31'd0, done}, 32'd1);
        chk("wd_pulsed", pcyc, 3);
        chk("wd_no_grant1", g1, 0);

        // reset during WAIT_DONE
        launch("rst", 4'b0100, 32'hE3E2E1E0, 4'b0100, 8'hE2);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk_29_pll);
            if (c == 0) i_req = '0;
            if (i_tx_busy) got = 1'b1;
        end
        chk("rst_saw_busy", {31'd0, got}, 32'd1);
        @(negedge clk_29_pll);
        reset = 1'b0;
        @(posedge clk_29_pll); #1;
        chk_rst_outputs("midrst");
        @(negedge clk_29_pll);
        reset = 1'b1;
        errs = 0;
        repeat (4) begin
            @(negedge clk_29_pll);
            if (o_err_timeout || o_active) errs++;
        end
        chk("midrst_quiet", errs, 0);
        busy_len = 3;
        run_vec("post_rst", 4'b1111, 32'hF3F2F1F0, 4'b0001, 8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
